// File: rtl/dyt_pkg.sv
// dyt_pkg: shared widths and operand-source helper for the operand fetch stage
package dyt_pkg;
    localparam int XLEN       = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    typedef enum logic [1:0] {SRC_ZERO, SRC_BYPASS, SRC_RF} op_src_e;
    // x0 always reads zero; a same-cycle writeback beats the register file
    function automatic op_src_e op_src(input logic is_x0, input logic bypass);
        return is_x0 ? SRC_ZERO : bypass ? SRC_BYPASS : SRC_RF;
    endfunction
endpackage

// File: rtl/dyt_operand_fetch_if.sv
// dyt_operand_fetch_if: bundle of the operand fetch stage's external signals
//   upstream   : in_valid/in_ready, in_rs1/in_rs2/in_rd, in_rd_we, in_pc
//   reg file   : r_a_addr/r_b_addr out, r_a_data/r_b_data in (combinational)
//   writeback  : wb_en, wb_addr, wb_data
//   downstream : out_valid/out_ready, out_rs1_data/out_rs2_data, out_pc, out_rd, out_rd_we
//   control    : flush in, pending (scoreboard state, observation only)
interface dyt_operand_fetch_if #(
    parameter int XLEN       = dyt_pkg::XLEN,
    parameter int ADDR_WIDTH = dyt_pkg::ADDR_WIDTH
);
    import dyt_pkg::*;
    logic                     in_valid;
    logic                     in_ready;
    logic [ADDR_WIDTH-1:0]    in_rs1;
    logic [ADDR_WIDTH-1:0]    in_rs2;
    logic [ADDR_WIDTH-1:0]    in_rd;
    logic                     in_rd_we;
    logic [XLEN-1:0]          in_pc;
    logic [ADDR_WIDTH-1:0]    r_a_addr;
    logic [ADDR_WIDTH-1:0]    r_b_addr;
    logic [XLEN-1:0]          r_a_data;
    logic [XLEN-1:0]          r_b_data;
    logic                     wb_en;
    logic [ADDR_WIDTH-1:0]    wb_addr;
    logic [XLEN-1:0]          wb_data;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_rs1_data;
    logic [XLEN-1:0]          out_rs2_data;
    logic [XLEN-1:0]          out_pc;
    logic [ADDR_WIDTH-1:0]    out_rd;
    logic                     out_rd_we;
    logic [2**ADDR_WIDTH-1:0] pending;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_pc, r_a_data, r_b_data,
               wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, r_a_addr, r_b_addr, out_valid, out_rs1_data, out_rs2_data,
               out_pc, out_rd, out_rd_we, pending
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_pc, r_a_data, r_b_data,
               wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, r_a_addr, r_b_addr, out_valid, out_rs1_data, out_rs2_data,
               out_pc, out_rd, out_rd_we, pending
    );
endinterface

// File: rtl/dyt_scoreboard.sv
// dyt_scoreboard: per-register pending bits with set-over-clear priority and hazard lookup
//   clk, rst           - clock, asynchronous active-low reset
//   set_en, set_addr   - mark a destination busy (instruction issued)
//   clr_en, clr_addr   - writeback retiring a destination
//   rs1, rs2, rd, rd_we - register numbers of the held instruction
//   hazard             - held instruction must wait
//   pending            - current busy bits, bit 0 always clear
module dyt_scoreboard #(
    parameter int ADDR_WIDTH = dyt_pkg::ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_WIDTH-1:0]    set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_WIDTH-1:0]    clr_addr,
    input  logic [ADDR_WIDTH-1:0]    rs1,
    input  logic [ADDR_WIDTH-1:0]    rs2,
    input  logic [ADDR_WIDTH-1:0]    rd,
    input  logic                     rd_we,
    output logic                     hazard,
    output logic [2**ADDR_WIDTH-1:0] pending
);
    import dyt_pkg::*;
    logic [2**ADDR_WIDTH-1:0] nxt;
    logic busy_rs1, busy_rs2, busy_rd;

    // a register being written back this cycle is already satisfied via the bypass
    assign busy_rs1 = rs1 != '0 && pending[rs1] && !(clr_en && clr_addr == rs1);
    assign busy_rs2 = rs2 != '0 && pending[rs2] && !(clr_en && clr_addr == rs2);
    assign busy_rd  = rd  != '0 && pending[rd]  && !(clr_en && clr_addr == rd);
    assign hazard   = busy_rs1 || busy_rs2 || (rd_we && busy_rd);

    // set is applied after clear so a new producer wins over an older writeback
    always_comb begin
        nxt = pending;
        if (clr_en) nxt[clr_addr] = 1'b0;
        if (set_en) nxt[set_addr] = 1'b1;
        nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) pending <= '0;
        else pending <= nxt;
endmodule

// File: rtl/dyt_operand_fetch.sv
// dyt_operand_fetch: one-entry operand fetch stage between decode and execute
//   clk - clock, all state on the rising edge
//   rst - asynchronous active-low reset
//   bus - decode handshake, register file reads, writeback bypass, flush, execute handshake
module dyt_operand_fetch #(
    parameter int XLEN       = dyt_pkg::XLEN,
    parameter int ADDR_WIDTH = dyt_pkg::ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    dyt_operand_fetch_if.slave bus
);
    import dyt_pkg::*;
    logic                  s_valid;
    logic [ADDR_WIDTH-1:0] s_rs1;
    logic [ADDR_WIDTH-1:0] s_rs2;
    logic [ADDR_WIDTH-1:0] s_rd;
    logic                  s_rd_we;
    logic [XLEN-1:0]       s_pc;
    logic                  hazard;
    logic                  issue;
    logic                  accept;
    op_src_e               a_src;
    op_src_e               b_src;

    assign bus.out_valid = s_valid && !hazard && !bus.flush;
    assign issue         = bus.out_valid && bus.out_ready;
    // flush also refuses new work so the killed slot is not refilled in the same cycle
    assign bus.in_ready  = !bus.flush && (!s_valid || issue);
    assign accept        = bus.in_valid && bus.in_ready;

    // held addresses drive the register file every cycle so a stalled instruction re-reads
    assign bus.r_a_addr  = s_rs1;
    assign bus.r_b_addr  = s_rs2;

    assign a_src = op_src(s_rs1 == '0, bus.wb_en && bus.wb_addr == s_rs1);
    assign b_src = op_src(s_rs2 == '0, bus.wb_en && bus.wb_addr == s_rs2);
    assign bus.out_rs1_data = (!s_valid || a_src == SRC_ZERO) ? '0 :
                              (a_src == SRC_BYPASS) ? bus.wb_data : bus.r_a_data;
    assign bus.out_rs2_data = (!s_valid || b_src == SRC_ZERO) ? '0 :
                              (b_src == SRC_BYPASS) ? bus.wb_data : bus.r_b_data;
    assign bus.out_pc    = s_pc;
    assign bus.out_rd    = s_rd;
    assign bus.out_rd_we = s_rd_we;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s_valid <= 1'b0;
            s_rs1   <= '0;
            s_rs2   <= '0;
            s_rd    <= '0;
            s_rd_we <= 1'b0;
            s_pc    <= '0;
        end else if (accept) begin
            s_valid <= 1'b1;
            s_rs1   <= bus.in_rs1;
            s_rs2   <= bus.in_rs2;
            s_rd    <= bus.in_rd;
            s_rd_we <= bus.in_rd_we;
            s_pc    <= bus.in_pc;
        end else if (bus.flush || issue) begin
            s_valid <= 1'b0;
        end

    dyt_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue && s_rd_we && s_rd != '0),
        .set_addr (s_rd),
        .clr_en   (bus.wb_en),
        .clr_addr (bus.wb_addr),
        .rs1      (s_rs1),
        .rs2      (s_rs2),
        .rd       (s_rd),
        .rd_we    (s_rd_we),
        .hazard   (hazard),
        .pending  (bus.pending)
    );
endmodule

// File: tb/tb_dyt_operand_fetch.sv
// tb_dyt_operand_fetch: directed vector table, flush/reset sequences and randomized model check
module tb_dyt_operand_fetch;
    import dyt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dyt_operand_fetch_if bus ();
    dyt_operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] rf [NUM_REGS];
    assign bus.r_a_data = rf[bus.r_a_addr];
    assign bus.r_b_data = rf[bus.r_b_addr];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [3:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] pc;
        logic        wbe;
        logic [3:0]  wba;
        logic [31:0] wbd;
        logic        fl, ordy;
        logic        e_ov, e_ir;
        logic [31:0] e_a, e_b, e_pc;
        logic [3:0]  e_rd;
        logic [15:0] e_pend;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid  = v.iv;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_rd     = v.rd;
        bus.in_rd_we  = v.we;
        bus.in_pc     = v.pc;
        bus.wb_en     = v.wbe;
        bus.wb_addr   = v.wba;
        bus.wb_data   = v.wbd;
        bus.flush     = v.fl;
        bus.out_ready = v.ordy;
    endtask

    task automatic set_in(input logic iv, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [3:0] rd, input logic [31:0] pc, input logic fl);
        vec_t v;
        v = '{iv, rs1, rs2, rd, 1'b1, pc, 1'b0, 4'd0, 32'd0, fl, 1'b1,
              1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 16'd0};
        drive(v);
    endtask

    task automatic chk_basic(input string tag, input logic ov, input logic ir, input logic [15:0] pend);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(ir));
        chk({tag, " pending"}, 32'(bus.pending), 32'(pend));
    endtask

    // reference model state
    logic        m_valid;
    logic [3:0]  m_rs1, m_rs2, m_rd;
    logic        m_we;
    logic [31:0] m_pc;
    logic [15:0] m_pend;

    function automatic logic busy(input logic [3:0] r, input logic wbe, input logic [3:0] wba);
        return r != 0 && m_pend[r] && !(wbe && wba == r);
    endfunction

    function automatic logic [31:0] opnd(input logic v, input logic [3:0] r, input logic wbe,
                                         input logic [3:0] wba, input logic [31:0] wbd);
        if (!v || r == 0) return 32'd0;
        if (wbe && wba == r) return wbd;
        return rf[r];
    endfunction

    initial begin
        vec_t r;
        logic e_ov, e_ir, haz, iss;

        r = '{1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0,
              1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 16'd0};
        drive(r);
        rf[0] = 32'hDEAD_BEEF;
        for (int i = 1; i < NUM_REGS; i++) rf[i] = 32'(i) << 8;
        rf[1] = 32'd5;
        rf[2] = 32'd7;

        //           iv rs1 rs2 rd we pc       wbe wba wbd            fl ordy ov ir a        b  pc       rd pend
        tbl[0]  = '{1, 1, 2, 3, 1, 'h100, 0, 0, 0,             0, 1,  0, 1, 0,      0, 0,      0, 'h0000};
        tbl[1]  = '{0, 0, 0, 0, 0, 0,     0, 0, 0,             0, 1,  1, 1, 5,      7, 'h100,  3, 'h0000};
        tbl[2]  = '{1, 3, 1, 5, 1, 'h104, 0, 0, 0,             0, 1,  0, 1, 0,      0, 0,      0, 'h0008};
        tbl[3]  = '{0, 0, 0, 0, 0, 0,     0, 0, 0,             0, 1,  0, 0, 'h300,  5, 0,      0, 'h0008};
        tbl[4]  = '{0, 0, 0, 0, 0, 0,     0, 0, 0,             0, 1,  0, 0, 'h300,  5, 0,      0, 'h0008};
        tbl[5]  = '{0, 0, 0, 0, 0, 0,     1, 3, 12,            0, 1,  1, 1, 12,     5, 'h104,  5, 'h0008};
        tbl[6]  = '{1, 0, 0, 6, 1, 'h108, 1, 0, 'hFFFF_FFFF,   0, 1,  0, 1, 0,      0, 0,      0, 'h0020};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,     1, 0, 'hFFFF_FFFF,   0, 1,  1, 1, 0,      0, 'h108,  6, 'h0020};
        tbl[8]  = '{1, 1, 2, 7, 1, 'h10C, 0, 0, 0,             0, 0,  0, 1, 0,      0, 0,      0, 'h0060};
        tbl[9]  = '{1, 2, 1, 8, 1, 'h110, 0, 0, 0,             0, 0,  1, 0, 5,      7, 'h10C,  7, 'h0060};
        tbl[10] = '{1, 2, 1, 8, 1, 'h110, 0, 0, 0,             0, 0,  1, 0, 5,      7, 'h10C,  7, 'h0060};
        tbl[11] = '{1, 2, 1, 8, 1, 'h110, 0, 0, 0,             0, 0,  1, 0, 5,      7, 'h10C,  7, 'h0060};
        tbl[12] = '{1, 2, 1, 8, 1, 'h110, 0, 0, 0,             0, 1,  1, 1, 5,      7, 'h10C,  7, 'h0060};
        tbl[13] = '{0, 0, 0, 0, 0, 0,     0, 0, 0,             0, 1,  1, 1, 7,      5, 'h110,  8, 'h00E0};
        tbl[14] = '{1, 1, 2, 4, 1, 'h114, 0, 0, 0,             0, 1,  0, 1, 0,      0, 0,      0, 'h01E0};
        tbl[15] = '{0, 0, 0, 0, 0, 0,     1, 4, 'h44,          0, 1,  1, 1, 5,      7, 'h114,  4, 'h01E0};
        tbl[16] = '{0, 0, 0, 0, 0, 0,     0, 0, 0,             0, 1,  0, 1, 0,      0, 0,      0, 'h01F0};

        #2 rst = 1'b0;
        @(negedge clk); #1;
        chk_basic("reset", 1'b0, 1'b1, 16'h0000);
        chk("reset out_rd", 32'(bus.out_rd), 32'd0);
        chk("reset out_rd_we", 32'(bus.out_rd_we), 32'd0);
        chk("reset out_pc", bus.out_pc, 32'd0);
        chk("reset rs1_data", bus.out_rs1_data, 32'd0);
        chk("reset rs2_data", bus.out_rs2_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk_basic($sformatf("v%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_pend);
            chk($sformatf("v%0d rs1_data", i), bus.out_rs1_data, tbl[i].e_a);
            chk($sformatf("v%0d rs2_data", i), bus.out_rs2_data, tbl[i].e_b);
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d out_pc", i), bus.out_pc, tbl[i].e_pc);
                chk($sformatf("v%0d out_rd", i), 32'(bus.out_rd), 32'(tbl[i].e_rd));
            end
            if (tbl[i].wbe && tbl[i].wba != 0) rf[tbl[i].wba] = tbl[i].wbd;
        end

        // flush of a stalled instruction; the waiting decode request must not slip in
        @(negedge clk); set_in(1, 5, 1, 9, 'h200, 0); #1;
        chk_basic("fl0", 1'b0, 1'b1, 16'h01F0);
        @(negedge clk); set_in(1, 1, 2, 10, 'h204, 0); #1;
        chk_basic("fl1", 1'b0, 1'b0, 16'h01F0);
        chk("fl1 rs1_data", bus.out_rs1_data, 32'h500);
        @(negedge clk); set_in(1, 1, 2, 10, 'h204, 1); #1;
        chk_basic("fl2", 1'b0, 1'b0, 16'h01F0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0); #1;
        chk_basic("fl3", 1'b0, 1'b1, 16'h01F0);
        chk("fl3 rs1_data", bus.out_rs1_data, 32'd0);

        // asynchronous reset while stalled, then acceptance on the first edge after release
        @(negedge clk); set_in(1, 5, 0, 11, 'h208, 0); #1;
        chk_basic("rs0", 1'b0, 1'b1, 16'h01F0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0); #1;
        chk_basic("rs1", 1'b0, 1'b0, 16'h01F0);
        #1 rst = 1'b0;
        #1;
        chk_basic("rs2", 1'b0, 1'b1, 16'h0000);
        chk("rs2 rs1_data", bus.out_rs1_data, 32'd0);
        chk("rs2 out_pc", bus.out_pc, 32'd0);
        chk("rs2 out_rd", 32'(bus.out_rd), 32'd0);
        chk("rs2 out_rd_we", 32'(bus.out_rd_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        set_in(1, 1, 2, 3, 'h300, 0); #1;
        chk_basic("rs3", 1'b0, 1'b1, 16'h0000);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0); #1;
        chk_basic("rs4", 1'b1, 1'b1, 16'h0000);
        chk("rs4 rs1_data", bus.out_rs1_data, 32'd5);
        chk("rs4 rs2_data", bus.out_rs2_data, 32'd7);
        chk("rs4 out_pc", bus.out_pc, 32'h300);
        @(negedge clk); #1;
        chk_basic("rs5", 1'b0, 1'b1, 16'h0008);

        // clean restart for the randomized phase
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_we = 0; m_pc = 0;
        m_pend = 16'h0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r.iv   = $urandom_range(0, 3) != 0;
            r.rs1  = 4'($urandom_range(0, 15));
            r.rs2  = 4'($urandom_range(0, 15));
            r.rd   = 4'($urandom_range(0, 15));
            r.we   = $urandom_range(0, 3) != 0;
            r.pc   = $urandom;
            r.wbe  = $urandom_range(0, 9) < 4;
            r.wba  = 4'($urandom_range(0, 15));
            r.wbd  = $urandom;
            r.fl   = $urandom_range(0, 31) == 0;
            r.ordy = $urandom_range(0, 3) != 0;
            drive(r);
            #1;
            haz  = busy(m_rs1, r.wbe, r.wba) || busy(m_rs2, r.wbe, r.wba) ||
                   (m_we && busy(m_rd, r.wbe, r.wba));
            e_ov = m_valid && !haz && !r.fl;
            e_ir = !r.fl && (!m_valid || (e_ov && r.ordy));
            chk_basic($sformatf("r%0d", c), e_ov, e_ir, m_pend);
            chk($sformatf("r%0d rs1_data", c), bus.out_rs1_data, opnd(m_valid, m_rs1, r.wbe, r.wba, r.wbd));
            chk($sformatf("r%0d rs2_data", c), bus.out_rs2_data, opnd(m_valid, m_rs2, r.wbe, r.wba, r.wbd));
            if (e_ov) begin
                chk($sformatf("r%0d out_pc", c), bus.out_pc, m_pc);
                chk($sformatf("r%0d out_rd", c), 32'(bus.out_rd), 32'(m_rd));
                chk($sformatf("r%0d out_rd_we", c), 32'(bus.out_rd_we), 32'(m_we));
            end
            iss = e_ov && r.ordy;
            if (r.wbe) m_pend[r.wba] = 1'b0;
            if (iss && m_we && m_rd != 0) m_pend[m_rd] = 1'b1;
            if (r.wbe && r.wba != 0) rf[r.wba] = r.wbd;
            if (r.fl) m_valid = 1'b0;
            else if (e_ir && r.iv) begin
                m_valid = 1'b1;
                m_rs1 = r.rs1; m_rs2 = r.rs2; m_rd = r.rd; m_we = r.we; m_pc = r.pc;
            end else if (iss) m_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
